// File: rtl/apb_sl_regbank.sv
// ============================================================================
// Module      : apb_sl_regbank
// Description : APB slave with N_CH channels of DATA / CONFIG / STATUS regs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_sl_regbank #(
  parameter int                    ADDR_WIDTH  = 10,
  parameter int                    N_CH        = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(4),
  parameter int                    CFG_WIDTH   = 8,
  parameter int                    ST_WIDTH    = 8,
  parameter logic [CFG_WIDTH-1:0]  CFG_RESET   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic [ADDR_WIDTH-1:0]     paddr,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [31:0]               pwdata,
  input  logic [3:0]                pstrb,
  output logic                      pready,
  output logic                      pslverr,
  output logic [31:0]               prdata,
  output logic [N_CH*CFG_WIDTH-1:0] cfg_out,
  output logic [N_CH*32-1:0]        data_out,
  output logic [N_CH-1:0]           data_wr_pulse,
  input  logic [N_CH*ST_WIDTH-1:0]  status_set
);

  localparam int c_CH_W = ADDR_WIDTH - 2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_cnt;
  logic [2:0]            w_cnt_nxt;

  logic [ADDR_WIDTH-1:0] w_rel;
  logic [c_CH_W-1:0]     w_ch_idx;
  logic [1:0]            w_off;
  logic                  w_below;
  logic [N_CH-1:0]       w_hit;
  logic                  w_err;
  logic                  w_ready;
  logic                  w_commit;
  logic [31:0]           w_mask;
  logic [N_CH-1:0][31:0] w_rd_data;
  logic [31:0]           w_rd_sel;

  // Address decode relative to channel 0 DATA; four words per channel.
  assign w_rel    = paddr - BASE_ADDR;
  assign w_ch_idx = w_rel[ADDR_WIDTH-1:2];
  assign w_off    = w_rel[1:0];
  assign w_below  = (paddr < BASE_ADDR);
  assign w_err    = w_below || !(|w_hit) || (w_off == 2'd3) || (!pwrite && (|pstrb));
  assign w_mask   = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};

  // Reset gating keeps the bus outputs quiet while preset_n is held low.
  assign w_ready  = preset_n && (r_state == ST_ACCESS) && (r_cnt == 3'd0) && psel && penable;
  assign w_commit = w_ready && !w_err && pwrite;

  assign pready   = w_ready;
  assign pslverr  = w_ready && w_err;
  assign prdata   = (w_ready && !pwrite && !w_err) ? w_rd_sel : 32'h0;

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (psel && !penable) begin
          w_state_nxt = ST_ACCESS;
          w_cnt_nxt   = 3'(WAIT_STATES);
        end
      end
      ST_ACCESS: begin
        // Dropping psel early abandons the transfer without committing.
        if (!psel || w_ready) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 3'd0;
        end else if (r_cnt != 3'd0) begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_comb begin
    w_rd_sel = 32'h0;
    for (int c = 0; c < N_CH; c++) begin
      if (w_hit[c]) begin
        w_rd_sel = w_rd_data[c];
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [31:0]          r_data;
    logic [CFG_WIDTH-1:0] r_cfg;
    logic [ST_WIDTH-1:0]  r_st;
    logic                 r_pulse;
    logic                 w_sel_data;
    logic                 w_sel_cfg;
    logic                 w_sel_st;
    logic [ST_WIDTH-1:0]  w_st_clr;

    assign w_hit[c]   = !w_below && (w_ch_idx == c_CH_W'(c));
    assign w_sel_data = w_commit && w_hit[c] && (w_off == 2'd0);
    assign w_sel_cfg  = w_commit && w_hit[c] && (w_off == 2'd1);
    assign w_sel_st   = w_commit && w_hit[c] && (w_off == 2'd2);
    assign w_st_clr   = w_sel_st ? (pwdata[ST_WIDTH-1:0] & w_mask[ST_WIDTH-1:0]) : '0;

    always_ff @(posedge pclk) begin
      if (!preset_n) begin
        r_data  <= 32'h0;
        r_cfg   <= CFG_RESET;
        r_st    <= '0;
        r_pulse <= 1'b0;
      end else begin
        if (w_sel_data) begin
          r_data <= (r_data & ~w_mask) | (pwdata & w_mask);
        end
        if (w_sel_cfg) begin
          r_cfg <= (r_cfg & ~w_mask[CFG_WIDTH-1:0]) | (pwdata[CFG_WIDTH-1:0] & w_mask[CFG_WIDTH-1:0]);
        end
        // Set is applied after clear so a simultaneous set survives.
        r_st    <= (r_st & ~w_st_clr) | status_set[c*ST_WIDTH +: ST_WIDTH];
        r_pulse <= w_sel_data;
      end
    end

    assign w_rd_data[c] = (w_off == 2'd0) ? r_data :
                          (w_off == 2'd1) ? 32'(r_cfg) :
                          (w_off == 2'd2) ? 32'(r_st) : 32'h0;

    assign cfg_out[c*CFG_WIDTH +: CFG_WIDTH] = r_cfg;
    assign data_out[c*32 +: 32]              = r_data;
    assign data_wr_pulse[c]                  = r_pulse;
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_sl_regbank.sv
// ============================================================================
// Module      : tb_apb_sl_regbank
// Description : Bench for apb_sl_regbank with zero and three wait states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_sl_regbank;

  localparam int         N_CH     = 4;
  localparam logic [7:0] CFG_RST0 = 8'h00;
  localparam logic [7:0] CFG_RST3 = 8'hA5;

  logic         pclk = 1'b0;
  logic         preset_n = 1'b0;
  logic [9:0]   paddr = '0;
  logic         psel0 = 1'b0, psel3 = 1'b0;
  logic         penable = 1'b0, pwrite = 1'b0;
  logic [31:0]  pwdata = '0;
  logic [3:0]   pstrb = '0;
  logic [31:0]  st_set = '0;

  logic         pready0, pslverr0, pready3, pslverr3;
  logic [31:0]  prdata0, prdata3, cfg0, cfg3;
  logic [127:0] data0, data3;
  logic [3:0]   pulse0, pulse3;

  always #5 pclk = ~pclk;

  apb_sl_regbank #(.ADDR_WIDTH(10), .N_CH(N_CH), .BASE_ADDR(10'd4), .CFG_WIDTH(8),
                   .ST_WIDTH(8), .CFG_RESET(CFG_RST0), .WAIT_STATES(0)) u_dut0 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready0), .pslverr(pslverr0),
    .prdata(prdata0), .cfg_out(cfg0), .data_out(data0), .data_wr_pulse(pulse0),
    .status_set(st_set));

  apb_sl_regbank #(.ADDR_WIDTH(10), .N_CH(N_CH), .BASE_ADDR(10'd4), .CFG_WIDTH(8),
                   .ST_WIDTH(8), .CFG_RESET(CFG_RST3), .WAIT_STATES(3)) u_dut3 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel3), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready3), .pslverr(pslverr3),
    .prdata(prdata3), .cfg_out(cfg3), .data_out(data3), .data_wr_pulse(pulse3),
    .status_set(st_set));

  // Reference register file: index 0 is the zero-wait slave, 1 the three-wait slave.
  logic [31:0] m_data [2][N_CH];
  logic [7:0]  m_cfg  [2][N_CH];
  logic [7:0]  m_st   [2][N_CH];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_models();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < N_CH; c++) begin
        m_data[k][c] = 32'h0;
        m_cfg[k][c]  = (k == 0) ? CFG_RST0 : CFG_RST3;
        m_st[k][c]   = 8'h0;
      end
  endtask

  task automatic apply_set(input logic [31:0] v);
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < N_CH; c++) m_st[k][c] = m_st[k][c] | v[c*8 +: 8];
  endtask

  function automatic logic [127:0] exp_data(input int k);
    logic [127:0] r;
    for (int c = 0; c < N_CH; c++) r[c*32 +: 32] = m_data[k][c];
    return r;
  endfunction

  function automatic logic [127:0] exp_cfg(input int k);
    logic [127:0] r = '0;
    for (int c = 0; c < N_CH; c++) r[c*8 +: 8] = m_cfg[k][c];
    return r;
  endfunction

  function automatic logic get_rdy(input int k);     return k ? pready3  : pready0;  endfunction
  function automatic logic get_err(input int k);     return k ? pslverr3 : pslverr0; endfunction
  function automatic logic [31:0] get_rd(input int k); return k ? prdata3 : prdata0;  endfunction
  function automatic logic [3:0] get_pulse(input int k); return k ? pulse3 : pulse0;  endfunction
  function automatic logic [127:0] get_data(input int k); return k ? data3 : data0;   endfunction
  function automatic logic [31:0] get_cfg(input int k); return k ? cfg3 : cfg0;      endfunction

  task automatic check_regs(input string tag, input int k);
    chk({tag, "_data"}, get_data(k), exp_data(k));
    chk({tag, "_cfg"}, 128'(get_cfg(k)), exp_cfg(k));
  endtask

  // One complete APB transfer; psel/penable are left high so a following call is back-to-back.
  task automatic apb(input string tag, input int k, input int addr, input bit wr,
                     input logic [31:0] wd, input logic [3:0] st, output logic [31:0] rd);
    int ch, off, waits;
    bit err;
    logic [31:0] mask, exp_rd;
    logic [3:0] exp_pulse;
    ch  = (addr < 4) ? 0 : (addr - 4) / 4;
    off = (addr < 4) ? 0 : (addr - 4) % 4;
    err = (addr < 4) || (ch >= N_CH) || (off == 3) || (!wr && st != 4'h0);
    for (int b = 0; b < 4; b++) mask[b*8 +: 8] = st[b] ? 8'hFF : 8'h00;
    exp_rd = 32'h0;
    if (!err && !wr) exp_rd = (off == 0) ? m_data[k][ch] : (off == 1) ? 32'(m_cfg[k][ch]) : 32'(m_st[k][ch]);
    exp_pulse = 4'h0;

    @(negedge pclk);
    paddr = 10'(addr); pwrite = wr; pwdata = wd; pstrb = st;
    psel0 = (k == 0); psel3 = (k == 1); penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    waits = 0;
    while (!get_rdy(k) && waits < 20) begin
      @(negedge pclk); #1; waits++;
    end
    chk({tag, "_latency"}, 128'(waits), 128'((k == 0) ? 0 : 3));
    chk({tag, "_pslverr"}, 128'(get_err(k)), 128'(err));
    chk({tag, "_prdata"}, 128'(get_rd(k)), 128'(exp_rd));
    rd = get_rd(k);
    @(posedge pclk);
    if (!err && wr) begin
      case (off)
        0: begin m_data[k][ch] = (m_data[k][ch] & ~mask) | (wd & mask); exp_pulse[ch] = 1'b1; end
        1: m_cfg[k][ch] = (m_cfg[k][ch] & ~mask[7:0]) | (wd[7:0] & mask[7:0]);
        default: m_st[k][ch] = m_st[k][ch] & ~(wd[7:0] & mask[7:0]);
      endcase
    end
    #1;
    chk({tag, "_pulse"}, 128'(get_pulse(k)), 128'(exp_pulse));
    check_regs(tag, k);
  endtask

  task automatic status_pulse(input logic [31:0] v);
    @(negedge pclk);
    st_set = v;
    @(negedge pclk);
    st_set = 32'h0;
    apply_set(v);
  endtask

  logic [31:0] rd;

  initial begin
    reset_models();
    repeat (3) @(negedge pclk);
    #1;
    chk("rst_pready", {pready0, pready3}, 2'b00);
    chk("rst_pslverr", {pslverr0, pslverr3}, 2'b00);
    @(negedge pclk);
    preset_n = 1'b1;
    #1;
    check_regs("reset0", 0);
    check_regs("reset3", 1);
    chk("reset_cfg3_lit", 128'(cfg3), 128'(32'hA5A5_A5A5));
    chk("reset_pulse", {pulse0, pulse3}, 8'h00);

    apb("w_data0", 0, 4, 1'b1, 32'hA5A5_1234, 4'hF, rd);
    chk("w_data0_lit", 128'(data0[31:0]), 128'(32'hA5A5_1234));

    apb("r_cfg_ws3", 1, 9, 1'b0, 32'h0, 4'h0, rd);
    chk("r_cfg_ws3_lit", 128'(rd), 128'(32'h0000_00A5));

    apb("w_ch2_all", 0, 12, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
    apb("w_ch2_part", 0, 12, 1'b1, 32'h0, 4'b0101, rd);
    apb("r_ch2", 0, 12, 1'b0, 32'h0, 4'h0, rd);
    chk("r_ch2_lit", 128'(rd), 128'(32'hFF00_FF00));

    status_pulse(32'h0000_0008);
    apb("r_st0a", 0, 6, 1'b0, 32'h0, 4'h0, rd);
    chk("st_set_lit", 128'(rd), 128'(32'h8));
    st_set = 32'h0000_0008;
    apb("w1c_with_set", 0, 6, 1'b1, 32'h8, 4'hF, rd);
    st_set = 32'h0;
    apply_set(32'h0000_0008);
    apb("r_st0b", 0, 6, 1'b0, 32'h0, 4'h0, rd);
    chk("set_wins_lit", 128'(rd), 128'(32'h8));
    apb("w1c_plain", 0, 6, 1'b1, 32'h8, 4'hF, rd);
    apb("r_st0c", 0, 6, 1'b0, 32'h0, 4'h0, rd);
    chk("w1c_clear_lit", 128'(rd), 128'(32'h0));

    apb("err_off3", 0, 7, 1'b1, 32'hDEAD_BEEF, 4'hF, rd);
    apb("err_ch", 0, 4 + 4 * N_CH, 1'b1, 32'hDEAD_BEEF, 4'hF, rd);
    apb("err_low", 0, 0, 1'b1, 32'hDEAD_BEEF, 4'hF, rd);
    apb("err_rstrb", 0, 4, 1'b0, 32'h0, 4'h1, rd);
    apb("err_ws3", 1, 7, 1'b0, 32'h0, 4'h0, rd);

    // psel withdrawn while the three-wait slave is still counting
    @(negedge pclk);
    paddr = 10'd9; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    psel0 = 1'b0; psel3 = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    chk("abort_sel_wait", 128'(pready3), 128'(1'b0));
    @(negedge pclk);
    psel3 = 1'b0;
    repeat (4) @(negedge pclk);
    #1;
    chk("abort_sel_pulse", 128'(pulse3), 128'(4'h0));
    check_regs("abort_sel", 1);
    apb("after_abort", 1, 9, 1'b0, 32'h0, 4'h0, rd);

    // reset asserted mid-transfer, with status set requests present during reset
    @(negedge pclk);
    paddr = 10'd4; pwrite = 1'b1; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
    psel0 = 1'b0; psel3 = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    preset_n = 1'b0;
    st_set = 32'hFFFF_FFFF;
    #1;
    chk("rstmid_pready", 128'(pready3), 128'(1'b0));
    chk("rstmid_pslverr", 128'(pslverr3), 128'(1'b0));
    chk("rstmid_prdata", 128'(prdata3), 128'(32'h0));
    @(negedge pclk);
    preset_n = 1'b1; st_set = 32'h0; psel3 = 1'b0; penable = 1'b0;
    reset_models();
    #1;
    chk("rstmid_pulse", {pulse0, pulse3}, 8'h00);
    check_regs("rstmid3", 1);
    check_regs("rstmid0", 0);
    apb("rstmid_st", 1, 6, 1'b0, 32'h0, 4'h0, rd);
    apb("rstmid_lat", 1, 4, 1'b1, 32'h1234_5678, 4'hF, rd);

    for (int i = 0; i < 250; i++) begin
      int k, addr;
      bit wr;
      logic [3:0] st;
      k    = int'($urandom_range(0, 1));
      addr = int'($urandom_range(0, 4 + 4 * N_CH + 3));
      wr   = 1'($urandom_range(0, 1));
      if (wr) st = 4'($urandom);
      else st = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      if ($urandom_range(0, 9) == 0) status_pulse($urandom);
      apb("rand", k, addr, wr, $urandom, st, rd);
    end

    @(negedge pclk);
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    repeat (3) @(negedge pclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/apb_sl_regbank.md
APB_SL_REGBANK -- requirements
Module: apb_sl_regbank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, APB word-address width.
REQ-002 SHALL have parameter N_CH, default 4, channel count, range 1..16.
REQ-003 SHALL have parameter BASE_ADDR, default 10'd4, word address of channel 0 DATA.
REQ-004 SHALL have parameter CFG_WIDTH, default 8, config register width, range 1..32.
REQ-005 SHALL have parameter ST_WIDTH, default 8, status register width, range 1..32.
REQ-006 SHALL have parameter CFG_RESET, default 0, reset value of every config register.
REQ-007 SHALL have parameter WAIT_STATES, default 0, access-phase wait cycles, range 0..7.
REQ-008 pclk  in  1  single clock; all logic on its rising edge.
REQ-009 preset_n  in  1  reset, synchronous, active-low.
REQ-010 paddr  in  ADDR_WIDTH  word address.
REQ-011 psel, penable, pwrite  in  1 each  APB controls.
REQ-012 pwdata  in  32  write data; pstrb  in  4  byte strobes.
REQ-013 pready, pslverr  out  1 each; prdata  out  32.
REQ-014 cfg_out  out  N_CH*CFG_WIDTH  config registers, channel c at [c*CFG_WIDTH +: CFG_WIDTH].
REQ-015 data_out  out  N_CH*32  data registers, channel c at [c*32 +: 32].
REQ-016 data_wr_pulse  out  N_CH  one-cycle pulse per committed DATA write.
REQ-017 status_set  in  N_CH*ST_WIDTH  sticky status set requests.

Function
REQ-018 Map: channel c at BASE_ADDR+4c; offset 0 DATA (RW, 32b), 1 CONFIG (RW), 2 STATUS (read, write-1-to-clear), 3 reserved.
REQ-019 Decode error SHALL be flagged for: paddr < BASE_ADDR, channel index >= N_CH, offset 3, or read with pstrb != 0.
REQ-020 FSM states IDLE, ACCESS; IDLE->ACCESS on psel=1,penable=0 (setup), loading wait counter with WAIT_STATES.
REQ-021 In ACCESS counter decrements to 0 and holds; pready = (state==ACCESS && cnt==0 && psel && penable).
REQ-022 Completion = rising edge with pready=1; FSM returns to IDLE; next setup may follow immediately (back-to-back).
REQ-023 psel deasserted in ACCESS before completion SHALL abort: return to IDLE, no register change.
REQ-024 penable=1 while IDLE SHALL be ignored.
REQ-025 Writes commit only at completion; DATA and CONFIG honour pstrb per byte; CONFIG bits beyond CFG_WIDTH discarded.
REQ-026 STATUS write clears bits where pwdata=1 and covering strobe=1; bits beyond ST_WIDTH ignored.
REQ-027 Status bit set every cycle status_set bit=1; simultaneous set and clear: set wins.
REQ-028 prdata = selected register zero-extended while pready=1 and read without error, else 32'h0.
REQ-029 pslverr = 1 only while pready=1 and decode error; errored access SHALL change no register.
REQ-030 data_wr_pulse[c] = 1 the cycle after a committed DATA write to channel c (including pstrb=0), else 0.
REQ-031 Completion latency: WAIT_STATES+1 cycles after setup cycle.

Reset
REQ-032 preset_n=0 at rising edge SHALL set: FSM IDLE, counter 0, DATA 0, STATUS 0, CONFIG CFG_RESET, data_wr_pulse 0.
REQ-033 During reset pready=0, pslverr=0, prdata=0; reset mid-transfer SHALL abort without commit.
REQ-034 status_set SHALL be ignored while preset_n=0.

Verification
REQ-035 WAIT_STATES=0: write 32'hA5A5_1234, pstrb 4'hF, paddr 4 -> pready in first access cycle; data_out[31:0]=32'hA5A5_1234; data_wr_pulse[0] one cycle after.
REQ-036 WAIT_STATES=3: read paddr 9 (ch1 CONFIG) -> pready after 3 wait cycles, prdata=CFG_RESET, pslverr 0.
REQ-037 Partial strobe: DATA ch2=32'hFFFF_FFFF, write 32'h0 pstrb 4'b0101 to paddr 12 -> readback 32'hFF00_FF00.
REQ-038 status_set ch0 bit3 pulsed, then W1C 32'h8 to paddr 6 in same cycle status_set bit3=1 -> bit3 stays 1; next W1C without set -> 0.
REQ-039 Errors: paddr 7, paddr 4+4*N_CH, paddr 0, read with pstrb 4'h1 -> pslverr=1, prdata=0, no register change.
REQ-040 Abort: psel dropped during wait (WAIT_STATES=3) and preset_n=0 mid-access -> no commit, no pulse, FSM IDLE.
